// File: rtl/paralelo_serial.sv
// Serial link transmitter: sends SYNC_COMMAS commas after reset, then MSB-first bytes with comma fill.
// Optional sticky comma_err output enabled by defining PS_COMMA_ERR_EN.
module paralelo_serial #(
  parameter logic [7:0]  COMMA_BYTE  = 8'hBC,
  parameter int unsigned SYNC_COMMAS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       load_out,
  output logic       sync_done
`ifdef PS_COMMA_ERR_EN
  ,
  output logic       comma_err
`endif
);

  localparam int unsigned CntW = $clog2(SYNC_COMMAS + 1);

  typedef enum logic [0:0] {StSync, StActive} state_e;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q, shreg_d;
  logic              data_out_q, data_out_d;
  logic              load_q, load_d;
  logic [CntW-1:0]   comma_cnt_q, comma_cnt_d;
  logic              load_edge;
  logic [7:0]        nb;

  always_comb begin
    load_edge   = (bit_cnt_q == 3'd7);
    nb          = COMMA_BYTE;
    if (state_q == StActive && valid_in) begin
      nb = data_in;
    end
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    load_d      = 1'b0;
    data_out_d  = shreg_q[7];
    shreg_d     = {shreg_q[6:0], 1'b0};
    if (load_edge) begin
      data_out_d = nb[7];
      shreg_d    = {nb[6:0], 1'b0};
      case (state_q)
        StSync: begin
          comma_cnt_d = comma_cnt_q + 1'b1;
          if (comma_cnt_q == CntW'(SYNC_COMMAS - 1)) begin
            state_d = StActive;
          end
        end
        StActive: load_d = 1'b1;
        default:  state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= StSync;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'd0;
      data_out_q  <= 1'b0;
      load_q      <= 1'b0;
      comma_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      load_q      <= load_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign load_out  = load_q;
  assign sync_done = (state_q == StActive);

`ifdef PS_COMMA_ERR_EN
  logic comma_err_q, comma_err_d;

  // Flags upstream sending the idle symbol as data; the byte still goes out.
  always_comb begin
    comma_err_d = comma_err_q;
    if (load_edge && state_q == StActive && valid_in && data_in == COMMA_BYTE) begin
      comma_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      comma_err_q <= 1'b0;
    end else begin
      comma_err_q <= comma_err_d;
    end
  end

  assign comma_err = comma_err_q;
`endif

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench for paralelo_serial: a slot-level link model predicts every output cycle.
module tb_paralelo_serial;

  localparam int         Sync  = 4;
  localparam logic [7:0] Comma = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       data_out, load_out, sync_done;
`ifdef PS_COMMA_ERR_EN
  logic       comma_err;
`endif

  paralelo_serial #(
    .COMMA_BYTE (Comma),
    .SYNC_COMMAS(Sync)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .load_out (load_out),
    .sync_done(sync_done)
`ifdef PS_COMMA_ERR_EN
    ,
    .comma_err(comma_err)
`endif
  );

  initial forever #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic d;
    logic ld;
    logic sd;
    logic ce;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] up_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n = 0;
  logic [7:0] cur = 8'd0;
  bit         sticky = 0;
  bit         junk_en = 0;
  bit         gap_en = 0;
  exp_t       m_e;
  exp_t       mon_e;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Link model: edge n after release; slot k=n/8 starts at edge 8k, commas for the first Sync slots.
  always @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      n      = 0;
      sticky = 0;
      cur    = 8'd0;
      exp_q.delete();
    end else begin
      n++;
      if (n % 8 == 0) begin
        if (n / 8 <= Sync || !valid_in) begin
          cur = Comma;
        end else begin
          cur = data_in;
          if (data_in == Comma) sticky = 1;
        end
      end
      m_e.d  = (n < 8) ? 1'b0 : cur[7 - (n % 8)];
      m_e.ld = (n % 8 == 0) && (n / 8 > Sync);
      m_e.sd = (n >= 8 * Sync);
      m_e.ce = sticky;
      exp_q.push_back(m_e);
    end
  end

  always @(posedge clk_32f) begin
    #1;
    if (!reset) begin
      chk("rst_data_out", data_out, 1'b0);
      chk("rst_load_out", load_out, 1'b0);
      chk("rst_sync_done", sync_done, 1'b0);
`ifdef PS_COMMA_ERR_EN
      chk("rst_comma_err", comma_err, 1'b0);
`endif
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      mon_e = exp_q.pop_front();
      chk("data_out", data_out, mon_e.d);
      chk("load_out", load_out, mon_e.ld);
      chk("sync_done", sync_done, mon_e.sd);
`ifdef PS_COMMA_ERR_EN
      chk("comma_err", comma_err, mon_e.ce);
`endif
    end
  end

  // Upstream: advances on load_out && valid_in; drives junk between load edges when enabled.
  always @(negedge clk_32f) begin
    if (reset && load_out && valid_in && up_q.size() > 0) begin
      void'(up_q.pop_front());
    end
    if ((n + 1) % 8 == 0) begin
      if (up_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
        valid_in = 1'b1;
        data_in  = up_q[0];
      end else begin
        valid_in = 1'b0;
        data_in  = 8'($urandom);
      end
    end else if (junk_en) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 3000 && up_q.size() > 0; i++) @(negedge clk_32f);
    chk("drain_timeout", up_q.size() == 0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;

    // Idle after release: 7 zeros, sync commas, then idle commas.
    repeat (100) @(negedge clk_32f);
    chk("sync_done_after_100", sync_done, 1'b1);

    up_q.push_back(8'hA5);
    wait_drain();
    repeat (16) @(negedge clk_32f);

    up_q.push_back(8'h00);
    up_q.push_back(8'hFF);
    up_q.push_back(8'h3C);
    wait_drain();
    repeat (16) @(negedge clk_32f);

    junk_en = 1;
    gap_en  = 1;
    for (int i = 0; i < 40; i++) up_q.push_back(8'($urandom));
    wait_drain();
    repeat (16) @(negedge clk_32f);
    junk_en = 0;
    gap_en  = 0;

    // Reset in the middle of a data byte.
    up_q.push_back(8'hA5);
    wait_drain();
    repeat (4) @(posedge clk_32f);
    #2 reset = 1'b0;
    #1;
    chk("midbyte_data_out", data_out, 1'b0);
    chk("midbyte_sync_done", sync_done, 1'b0);
    chk("midbyte_load_out", load_out, 1'b0);
    repeat (5) @(negedge clk_32f);
    reset = 1'b1;
    repeat (20) @(negedge clk_32f);
    chk("resync_not_done", sync_done, 1'b0);
    up_q.push_back(8'h5A);
    up_q.push_back(8'hC3);
    wait_drain();
    repeat (16) @(negedge clk_32f);

    // Valid comma as data: transmitted unchanged.
    up_q.push_back(Comma);
    up_q.push_back(8'h77);
    wait_drain();
    repeat (24) @(negedge clk_32f);
`ifdef PS_COMMA_ERR_EN
    chk("comma_err_sticky", comma_err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
